// File: rtl/tank_move_scheduler.sv
// Per-frame movement sequencer for two tanks sharing one wall checker, one pixel step per slot.
// Optional body-collision refusal between the tanks: define TANK_BODY_COLLIDE_EN.
module tank_move_scheduler #(
  parameter int STEPS_PER_FRAME = 2,
  parameter int CHK_LAT         = 1,
  parameter int X_MAX           = 607,
  parameter int Y_MAX           = 447,
  parameter int INIT_X1         = 64,
  parameter int INIT_Y1         = 64,
  parameter int INIT_X2         = 544,
  parameter int INIT_Y2         = 384
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic [2:0] dir1,
  input  logic [2:0] dir2,
  output logic [9:0] chk_x,
  output logic [9:0] chk_y,
  output logic [2:0] chk_dir,
  output logic       chk_sel,
  input  logic       chk_can_move,
  output logic [9:0] x_tank1,
  output logic [9:0] y_tank1,
  output logic [9:0] x_tank2,
  output logic [9:0] y_tank2,
  output logic       busy,
  output logic       blocked1,
  output logic       blocked2,
  output logic       overrun,
  output logic [2:0] fsm_state
);

  // Checker handshake: chk_* are valid from PRESENT through COMMIT and held stable;
  // chk_can_move is sampled only in COMMIT, CHK_LAT cycles after PRESENT.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LATCH   = 3'd1,
    S_PRESENT = 3'd2,
    S_WAIT    = 3'd3,
    S_COMMIT  = 3'd4
  } state_t;

  localparam logic [4:0] LAST_SLOT = 5'(2 * STEPS_PER_FRAME - 1);
  localparam logic [2:0] LAT       = 3'(CHK_LAT);
  localparam logic [9:0] X_LIM     = 10'(X_MAX);
  localparam logic [9:0] Y_LIM     = 10'(Y_MAX);

  state_t     state, next_state;
  logic [4:0] slot;
  logic [2:0] wait_cnt;
  logic [2:0] dir1_q, dir2_q;

  logic       sel, pres_sel;
  logic [2:0] cur_dir, pres_dir;
  logic [9:0] cur_x, cur_y, nxt_x, nxt_y;
  logic       dir_valid, in_bounds, collide, step_ok;

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (frame_tick) next_state = S_LATCH;
      S_LATCH:   next_state = S_PRESENT;
      S_PRESENT: next_state = (CHK_LAT == 0) ? S_COMMIT : S_WAIT;
      S_WAIT:    if (wait_cnt == LAT - 3'd1) next_state = S_COMMIT;
      S_COMMIT:  next_state = (slot == LAST_SLOT) ? S_IDLE : S_PRESENT;
      default:   next_state = S_IDLE;
    endcase
  end

  // Step evaluation for the tank owning the current slot.
  always_comb begin
    sel       = slot[0];
    cur_x     = sel ? x_tank2 : x_tank1;
    cur_y     = sel ? y_tank2 : y_tank1;
    cur_dir   = sel ? dir2_q : dir1_q;
    nxt_x     = cur_x;
    nxt_y     = cur_y;
    dir_valid = 1'b0;
    in_bounds = 1'b0;
    case (cur_dir)
      3'd1: begin dir_valid = 1'b1; in_bounds = (cur_y != 10'd0); nxt_y = cur_y - 10'd1; end
      3'd2: begin dir_valid = 1'b1; in_bounds = (cur_x < X_LIM);  nxt_x = cur_x + 10'd1; end
      3'd3: begin dir_valid = 1'b1; in_bounds = (cur_x != 10'd0); nxt_x = cur_x - 10'd1; end
      3'd4: begin dir_valid = 1'b1; in_bounds = (cur_y < Y_LIM);  nxt_y = cur_y + 10'd1; end
      default: ;
    endcase
  end

`ifdef TANK_BODY_COLLIDE_EN
  logic [9:0] oth_x, oth_y, dx, dy;
  always_comb begin
    oth_x   = sel ? x_tank1 : x_tank2;
    oth_y   = sel ? y_tank1 : y_tank2;
    dx      = (nxt_x >= oth_x) ? nxt_x - oth_x : oth_x - nxt_x;
    dy      = (nxt_y >= oth_y) ? nxt_y - oth_y : oth_y - nxt_y;
    collide = (dx < 10'd32) && (dy < 10'd32);
  end
`else
  assign collide = 1'b0;
`endif

  assign step_ok = dir_valid && chk_can_move && in_bounds && !collide;

  // Tank about to be presented: tank 1 straight after LATCH, otherwise the other tank.
  always_comb begin
    pres_sel = (state == S_LATCH) ? 1'b0 : ~slot[0];
    if (state == S_LATCH) pres_dir = dir1;
    else                  pres_dir = pres_sel ? dir2_q : dir1_q;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= S_IDLE;
      slot     <= '0;
      wait_cnt <= '0;
      dir1_q   <= '0;
      dir2_q   <= '0;
      x_tank1  <= 10'(INIT_X1);
      y_tank1  <= 10'(INIT_Y1);
      x_tank2  <= 10'(INIT_X2);
      y_tank2  <= 10'(INIT_Y2);
      blocked1 <= 1'b0;
      blocked2 <= 1'b0;
      overrun  <= 1'b0;
      chk_x    <= '0;
      chk_y    <= '0;
      chk_dir  <= '0;
      chk_sel  <= 1'b0;
    end else begin
      state   <= next_state;
      overrun <= frame_tick && (state != S_IDLE);
      case (state)
        S_LATCH: begin
          dir1_q   <= dir1;
          dir2_q   <= dir2;
          blocked1 <= 1'b0;
          blocked2 <= 1'b0;
          slot     <= '0;
        end
        S_PRESENT: wait_cnt <= '0;
        S_WAIT:    wait_cnt <= wait_cnt + 3'd1;
        S_COMMIT: begin
          slot <= slot + 5'd1;
          if (step_ok) begin
            if (sel) begin x_tank2 <= nxt_x; y_tank2 <= nxt_y; end
            else     begin x_tank1 <= nxt_x; y_tank1 <= nxt_y; end
          end else if (dir_valid) begin
            if (sel) blocked2 <= 1'b1;
            else     blocked1 <= 1'b1;
          end
        end
        default: ;
      endcase
      if (next_state == S_PRESENT) begin
        chk_sel <= pres_sel;
        chk_dir <= pres_dir;
        chk_x   <= pres_sel ? x_tank2 : x_tank1;
        chk_y   <= pres_sel ? y_tank2 : y_tank1;
      end
    end
  end

  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_tank_move_scheduler.sv
// Self-checking bench for tank_move_scheduler: randomized frames against a slot-by-slot position model.
module tb_tank_move_scheduler;
  localparam int S        = 2;
  localparam int L        = 1;
  localparam int XM       = 607;
  localparam int YM       = 447;
  localparam int BUSY_LEN = 1 + 2 * S * (L + 2);

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       frame_tick;
  logic [2:0] dir1, dir2;
  logic [9:0] chk_x, chk_y;
  logic [2:0] chk_dir;
  logic       chk_sel;
  logic       chk_can_move;
  logic [9:0] x_tank1, y_tank1, x_tank2, y_tank2;
  logic       busy, blocked1, blocked2, overrun;
  logic [2:0] fsm_state;
  logic       cm_t1, cm_t2;

  int vectors = 0;
  int miscompares = 0;
  int m_x[2], m_y[2];
  bit m_blk[2];

  tank_move_scheduler #(
    .STEPS_PER_FRAME(S), .CHK_LAT(L), .X_MAX(XM), .Y_MAX(YM),
    .INIT_X1(64), .INIT_Y1(64), .INIT_X2(544), .INIT_Y2(384)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
    .dir1(dir1), .dir2(dir2),
    .chk_x(chk_x), .chk_y(chk_y), .chk_dir(chk_dir), .chk_sel(chk_sel),
    .chk_can_move(chk_can_move),
    .x_tank1(x_tank1), .y_tank1(y_tank1), .x_tank2(x_tank2), .y_tank2(y_tank2),
    .busy(busy), .blocked1(blocked1), .blocked2(blocked2), .overrun(overrun),
    .fsm_state(fsm_state)
  );

  // Wall checker stand-in: verdict chosen per tank, held for the whole frame.
  assign chk_can_move = chk_sel ? cm_t2 : cm_t1;

  always #5 Clk = ~Clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    m_x[0] = 64;  m_y[0] = 64;
    m_x[1] = 544; m_y[1] = 384;
    m_blk[0] = 0; m_blk[1] = 0;
  endtask

  // Reference: 2*S slots alternating tank 1 / tank 2, each attempting one pixel.
  task automatic model_frame(input int d1, input int d2, input bit c1, input bit c2);
    m_blk[0] = 0;
    m_blk[1] = 0;
    for (int k = 0; k < 2 * S; k++) begin
      int t, d, nx, ny;
      bit ok;
      t  = k % 2;
      d  = (t == 1) ? d2 : d1;
      nx = m_x[t];
      ny = m_y[t];
      if (d >= 1 && d <= 4) begin
        if (d == 1) ny = ny - 1;
        if (d == 2) nx = nx + 1;
        if (d == 3) nx = nx - 1;
        if (d == 4) ny = ny + 1;
        ok = ((t == 1) ? c2 : c1) && nx >= 0 && nx <= XM && ny >= 0 && ny <= YM;
`ifdef TANK_BODY_COLLIDE_EN
        if (iabs(nx - m_x[1-t]) < 32 && iabs(ny - m_y[1-t]) < 32) ok = 0;
`endif
        if (ok) begin
          m_x[t] = nx;
          m_y[t] = ny;
        end else begin
          m_blk[t] = 1;
        end
      end
    end
  endtask

  function automatic bit model_match();
    return x_tank1 === 10'(m_x[0]) && y_tank1 === 10'(m_y[0]) &&
           x_tank2 === 10'(m_x[1]) && y_tank2 === 10'(m_y[1]) &&
           blocked1 === m_blk[0] && blocked2 === m_blk[1];
  endfunction

  // Runs one accepted frame. tick_at > 0 re-pulses frame_tick at that busy cycle.
  // Directions are scrambled once they have been latched.
  task automatic run_frame(input logic [2:0] d1, input logic [2:0] d2, input bit c1, input bit c2,
                           input int tick_at, output int blen, output int ov);
    dir1 = d1; dir2 = d2; cm_t1 = c1; cm_t2 = c2;
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    blen = 0;
    ov = 0;
    while (busy === 1'b1 && blen < 200) begin
      blen++;
      frame_tick = (blen == tick_at);
      if (blen == 2) begin
        dir1 = 3'($urandom_range(0, 7));
        dir2 = 3'($urandom_range(0, 7));
      end
      @(negedge Clk);
      if (overrun === 1'b1) ov++;
    end
    frame_tick = 1'b0;
    @(negedge Clk);
    if (overrun === 1'b1) ov++;
    if (busy !== 1'b0) blen += 1000;
  endtask

  task automatic report_pos(input string name);
    $display("FAIL %s: got t1=(%0d,%0d) t2=(%0d,%0d) blk=%b%b, expected t1=(%0d,%0d) t2=(%0d,%0d) blk=%b%b",
             name, x_tank1, y_tank1, x_tank2, y_tank2, blocked1, blocked2,
             m_x[0], m_y[0], m_x[1], m_y[1], m_blk[0], m_blk[1]);
  endtask

  task automatic test_reset();
    Reset_n = 1'b1; frame_tick = 1'b0; dir1 = '0; dir2 = '0; cm_t1 = 1'b1; cm_t2 = 1'b1;
    #2 Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    model_reset();
    vectors++;
    if (!model_match()) begin miscompares++; report_pos("reset_pos"); end
    vectors++;
    if (busy !== 1'b0 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got busy=%b overrun=%b, expected 0 0", busy, overrun);
    end
    vectors++;
    if (chk_x !== 10'd0 || chk_y !== 10'd0 || chk_dir !== 3'd0 || chk_sel !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_chk: got x=%0d y=%0d dir=%0d sel=%b, expected all 0", chk_x, chk_y, chk_dir, chk_sel);
    end
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_basic();
    int blen, ov;
    run_frame(3'd2, 3'd1, 1, 1, 0, blen, ov);
    model_frame(2, 1, 1, 1);
    vectors++;
    if (x_tank1 !== 10'd66 || y_tank2 !== 10'd382 || blocked1 !== 1'b0 || blocked2 !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_move: got x1=%0d y2=%0d blk=%b%b, expected x1=66 y2=382 blk=00",
               x_tank1, y_tank2, blocked1, blocked2);
    end
    vectors++;
    if (blen !== BUSY_LEN) begin
      miscompares++;
      $display("FAIL basic_busy_len: got %0d, expected %0d", blen, BUSY_LEN);
    end
    vectors++;
    if (ov !== 0) begin miscompares++; $display("FAIL basic_overrun: got %0d pulses, expected 0", ov); end
  endtask

  task automatic test_refuse_t1();
    int blen, ov;
    run_frame(3'd2, 3'd4, 0, 1, 0, blen, ov);
    model_frame(2, 4, 0, 1);
    vectors++;
    if (!model_match() || blocked1 !== 1'b1 || blocked2 !== 1'b0) begin
      miscompares++; report_pos("refuse_t1");
    end
  endtask

  task automatic test_random();
    int blen, ov, d1, d2;
    bit c1, c2;
    for (int i = 0; i < 30; i++) begin
      d1 = $urandom_range(0, 7);
      d2 = $urandom_range(0, 7);
      c1 = ($urandom_range(0, 3) != 0);
      c2 = ($urandom_range(0, 3) != 0);
      run_frame(3'(d1), 3'(d2), c1, c2, 0, blen, ov);
      model_frame(d1, d2, c1, c2);
      vectors++;
      if (!model_match()) begin miscompares++; report_pos("random_frame"); end
      vectors++;
      if (blen !== BUSY_LEN || ov !== 0) begin
        miscompares++;
        $display("FAIL random_timing: got busy_len=%0d overrun=%0d, expected %0d 0", blen, ov, BUSY_LEN);
      end
    end
  endtask

  // Drives tank 1 up to Y=0 and right to X=X_MAX, tank 2 down to Y=Y_MAX, then one more frame.
  task automatic test_bounds();
    int blen, ov, px, py;
    int errs;
    errs = 0;
    for (int i = 0; i < 300; i++) begin
      py = m_y[0];
      run_frame(3'd1, 3'd4, 1, 1, 0, blen, ov);
      model_frame(1, 4, 1, 1);
      if (!model_match()) errs++;
      if (m_y[0] == py) break;
    end
    vectors++;
    if (errs != 0 || y_tank1 !== 10'd0 || blocked1 !== 1'b1) begin
      miscompares++; report_pos("bound_up");
    end
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      px = m_x[0];
      run_frame(3'd2, 3'd4, 1, 1, 0, blen, ov);
      model_frame(2, 4, 1, 1);
      if (!model_match()) errs++;
      if (m_x[0] == px) break;
    end
    vectors++;
    if (errs != 0 || x_tank1 !== 10'(XM) || blocked1 !== 1'b1) begin
      miscompares++; report_pos("bound_right");
    end
    vectors++;
    if (y_tank2 !== 10'(YM) || blocked2 !== 1'b1) begin
      miscompares++; report_pos("bound_down");
    end
  endtask

  task automatic test_overrun();
    int blen, ov;
    run_frame(3'd3, 3'd1, 1, 1, 3, blen, ov);
    model_frame(3, 1, 1, 1);
    vectors++;
    if (ov !== 1 || blen !== BUSY_LEN) begin
      miscompares++;
      $display("FAIL overrun_mid: got pulses=%0d busy_len=%0d, expected 1 %0d", ov, blen, BUSY_LEN);
    end
    vectors++;
    if (!model_match()) begin miscompares++; report_pos("overrun_pos"); end
    run_frame(3'd4, 3'd2, 1, 1, BUSY_LEN, blen, ov);
    model_frame(4, 2, 1, 1);
    vectors++;
    if (ov !== 1 || blen !== BUSY_LEN) begin
      miscompares++;
      $display("FAIL overrun_last_commit: got pulses=%0d busy_len=%0d, expected 1 %0d", ov, blen, BUSY_LEN);
    end
    vectors++;
    if (!model_match()) begin miscompares++; report_pos("overrun_last_pos"); end
  endtask

  task automatic test_reset_mid_frame();
    int blen, ov;
    dir1 = 3'd3; dir2 = 3'd1; cm_t1 = 1'b1; cm_t2 = 1'b1;
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    repeat (5) @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (!model_match() || busy !== 1'b0) begin
      miscompares++; report_pos("reset_mid_wait");
      $display("FAIL reset_mid_wait_busy: got busy=%b, expected 0", busy);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    run_frame(3'd2, 3'd3, 1, 1, 0, blen, ov);
    model_frame(2, 3, 1, 1);
    vectors++;
    if (!model_match() || blen !== BUSY_LEN) begin
      miscompares++; report_pos("after_reset_frame");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_refuse_t1();
    test_random();
    test_bounds();
    test_overrun();
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
